// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the multicycle RV32I core control path.
//   - RV32I major opcodes (IR[6:0])
//   - sequencer state encoding
//   - alu_a_sel and wb_sel mux encodings
//   - opc_legal(): which major opcodes the sequencer executes
// ---------------------------------------------------------------------------
package rv_pkg;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   // ALU operand A source
   localparam logic [1:0] ALU_A_RS1  = 2'd0;
   localparam logic [1:0] ALU_A_PC   = 2'd1;
   localparam logic [1:0] ALU_A_ZERO = 2'd2;

   // Register-file write-back source
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;

   // SYSTEM is deliberately absent: ECALL/EBREAK/CSR halt the core.
   function automatic logic opc_legal(input logic [6:0] opc);
      logic ok;
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
         OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISCMEM: ok = 1'b1;
         default:                                             ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// ---------------------------------------------------------------------------
// retire_counter
// Free-running retired-instruction counter, wraps modulo 2^CNT_W.
//   clk    in   core clock
//   rst_n  in   asynchronous active-low clear
//   inc    in   count one retirement at this edge
//   count  out  current count
// ---------------------------------------------------------------------------
module retire_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (inc) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore sequencer for the multicycle RV32I datapath:
//   RESET -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, or TRAP.
// Owns the shared memory req/ack handshake and every datapath enable/select.
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   opcode, funct3      IR fields (opcode valid from DECODE onward)
//   branch_taken        ALU compare result, valid in EXEC
//   mem_ack             memory completes the current request at this edge
//   mem_req, mem_we     memory request / store
//   mem_addr_sel        0 = PC, 1 = ALU result
//   ir_we               load IR from memory read data
//   pc_we, pc_src_sel   PC update, 0 = PC+4, 1 = ALU result
//   alu_a_sel           rs1 / PC / zero
//   alu_b_sel           0 = rs2, 1 = immediate
//   rf_we, wb_sel       register write, source ALU / load / PC+4
//   trap                sticky halt on illegal or SYSTEM opcode
//   instret             retired-instruction count
// ---------------------------------------------------------------------------
module multicycle_control
   import rv_pkg::*;
#(
   parameter int CNT_W         = 32,
   parameter int RESET_PC_HOLD = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             branch_taken,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_src_sel,
   output logic [1:0]       alu_a_sel,
   output logic             alu_b_sel,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             trap,
   output logic [CNT_W-1:0] instret
);

   localparam logic [3:0] HOLD = 4'(RESET_PC_HOLD);

   state_t     state_reg;
   state_t     state_next;
   logic [3:0] hold_reg;

   // Registered outputs, loaded with the values that belong to state_next
   logic       mem_req_reg;
   logic       mem_we_reg;
   logic       mem_addr_sel_reg;
   logic       pc_we_reg;
   logic       pc_src_reg;
   logic       branch_exec_reg;
   logic [1:0] alu_a_sel_reg;
   logic       alu_b_sel_reg;
   logic       rf_we_reg;
   logic [1:0] wb_sel_reg;
   logic       trap_reg;

   logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
   logic is_load, is_store, is_op, is_miscmem;
   logic retire;
   logic [1:0] exec_a_sel;
   logic [1:0] wb_code;

   // funct3 only selects ALU/memory sub-operations in the datapath.
   logic unused_funct3;
   assign unused_funct3 = ^funct3;

   assign is_lui     = (opcode == OPC_LUI);
   assign is_auipc   = (opcode == OPC_AUIPC);
   assign is_jal     = (opcode == OPC_JAL);
   assign is_jalr    = (opcode == OPC_JALR);
   assign is_branch  = (opcode == OPC_BRANCH);
   assign is_load    = (opcode == OPC_LOAD);
   assign is_store   = (opcode == OPC_STORE);
   assign is_op      = (opcode == OPC_OP);
   assign is_miscmem = (opcode == OPC_MISCMEM);

   always_comb begin
      exec_a_sel = ALU_A_RS1;
      if (is_auipc || is_jal || is_branch) begin
         exec_a_sel = ALU_A_PC;
      end else if (is_lui) begin
         exec_a_sel = ALU_A_ZERO;
      end
   end

   always_comb begin
      wb_code = WB_ALU;
      if (is_load) begin
         wb_code = WB_LOAD;
      end else if (is_jal || is_jalr) begin
         wb_code = WB_PC4;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RESET:  if (hold_reg == HOLD) state_next = ST_FETCH;
         ST_FETCH:  if (mem_ack) state_next = ST_DECODE;
         ST_DECODE: state_next = opc_legal(opcode) ? ST_EXEC : ST_TRAP;
         ST_EXEC: begin
            if (is_branch || is_miscmem) begin
               state_next = ST_FETCH;
            end else if (is_load || is_store) begin
               state_next = ST_MEM;
            end else begin
               state_next = ST_WB;
            end
         end
         ST_MEM:    if (mem_ack) state_next = is_store ? ST_FETCH : ST_WB;
         ST_WB:     state_next = ST_FETCH;
         ST_TRAP:   state_next = ST_TRAP;
         default:   state_next = ST_RESET;
      endcase
   end

   // Retirement happens on the edge that leaves the retiring state.
   assign retire = ((state_reg == ST_EXEC) && (is_branch || is_miscmem)) ||
                   ((state_reg == ST_MEM) && is_store && mem_ack) ||
                   (state_reg == ST_WB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= ST_RESET;
         hold_reg         <= 4'd0;
         mem_req_reg      <= 1'b0;
         mem_we_reg       <= 1'b0;
         mem_addr_sel_reg <= 1'b0;
         pc_we_reg        <= 1'b0;
         pc_src_reg       <= 1'b0;
         branch_exec_reg  <= 1'b0;
         alu_a_sel_reg    <= ALU_A_RS1;
         alu_b_sel_reg    <= 1'b0;
         rf_we_reg        <= 1'b0;
         wb_sel_reg       <= WB_ALU;
         trap_reg         <= 1'b0;
      end else begin
         state_reg <= state_next;
         if ((state_reg == ST_RESET) && (hold_reg != HOLD)) begin
            hold_reg <= hold_reg + 4'd1;
         end
         // opcode is already valid whenever state_next is EXEC, MEM or WB,
         // so the per-state outputs can be registered one cycle early.
         mem_req_reg      <= (state_next == ST_FETCH) || (state_next == ST_MEM);
         mem_addr_sel_reg <= (state_next == ST_MEM);
         mem_we_reg       <= (state_next == ST_MEM) && is_store;
         pc_we_reg        <= (state_next == ST_WB) ||
                             ((state_next == ST_EXEC) && (is_branch || is_miscmem));
         pc_src_reg       <= (state_next == ST_WB) && (is_jal || is_jalr);
         branch_exec_reg  <= (state_next == ST_EXEC) && is_branch;
         alu_a_sel_reg    <= (state_next == ST_EXEC) ? exec_a_sel : ALU_A_RS1;
         alu_b_sel_reg    <= (state_next == ST_EXEC) && !(is_op || is_branch);
         rf_we_reg        <= (state_next == ST_WB);
         wb_sel_reg       <= (state_next == ST_WB) ? wb_code : WB_ALU;
         trap_reg         <= trap_reg || (state_next == ST_TRAP);
      end
   end

   retire_counter #(
      .CNT_W (CNT_W)
   ) u_retire_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (retire),
      .count (instret)
   );

   // Only the handshake-qualified strobes are combinational: IR load and the
   // store's PC update complete in the ack cycle, and the branch decision is
   // only known during EXEC. mem_we_reg is high exactly in MEM for a store.
   assign ir_we        = (state_reg == ST_FETCH) && mem_ack;
   assign pc_we        = pc_we_reg || (mem_we_reg && mem_ack);
   assign pc_src_sel   = pc_src_reg || (branch_exec_reg && branch_taken);
   assign mem_req      = mem_req_reg;
   assign mem_we       = mem_we_reg;
   assign mem_addr_sel = mem_addr_sel_reg;
   assign alu_a_sel    = alu_a_sel_reg;
   assign alu_b_sel    = alu_b_sel_reg;
   assign rf_we        = rf_we_reg;
   assign wb_sel       = wb_sel_reg;
   assign trap         = trap_reg;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   localparam logic [6:0] LUI     = 7'b0110111;
   localparam logic [6:0] AUIPC   = 7'b0010111;
   localparam logic [6:0] JAL     = 7'b1101111;
   localparam logic [6:0] JALR    = 7'b1100111;
   localparam logic [6:0] BRANCH  = 7'b1100011;
   localparam logic [6:0] LOAD    = 7'b0000011;
   localparam logic [6:0] STORE   = 7'b0100011;
   localparam logic [6:0] OPIMM   = 7'b0010011;
   localparam logic [6:0] OP      = 7'b0110011;
   localparam logic [6:0] MISCMEM = 7'b0001111;
   localparam logic [6:0] SYSTEM  = 7'b1110011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, rst_n_h;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       branch_taken, mem_ack, ack_h;

   // main DUT (CNT_W = 32)
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src_sel;
   logic [1:0]  alu_a_sel, wb_sel;
   logic        alu_b_sel, rf_we, trap;
   logic [31:0] instret;
   // narrow-counter DUT (CNT_W = 4), same stimulus
   logic        b_mem_req, b_mem_we, b_mem_addr_sel, b_ir_we, b_pc_we, b_pc_src_sel;
   logic [1:0]  b_alu_a_sel, b_wb_sel;
   logic        b_alu_b_sel, b_rf_we, b_trap;
   logic [3:0]  b_instret;
   // reset-hold DUT (RESET_PC_HOLD = 3)
   logic        h_mem_req, h_mem_we, h_mem_addr_sel, h_ir_we, h_pc_we, h_pc_src_sel;
   logic [1:0]  h_alu_a_sel, h_wb_sel;
   logic        h_alu_b_sel, h_rf_we, h_trap;
   logic [31:0] h_instret;

   multicycle_control #(.CNT_W(32), .RESET_PC_HOLD(0)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
      .branch_taken(branch_taken), .mem_ack(mem_ack), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
      .pc_src_sel(pc_src_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
      .rf_we(rf_we), .wb_sel(wb_sel), .trap(trap), .instret(instret));

   multicycle_control #(.CNT_W(4), .RESET_PC_HOLD(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
      .branch_taken(branch_taken), .mem_ack(mem_ack), .mem_req(b_mem_req),
      .mem_we(b_mem_we), .mem_addr_sel(b_mem_addr_sel), .ir_we(b_ir_we), .pc_we(b_pc_we),
      .pc_src_sel(b_pc_src_sel), .alu_a_sel(b_alu_a_sel), .alu_b_sel(b_alu_b_sel),
      .rf_we(b_rf_we), .wb_sel(b_wb_sel), .trap(b_trap), .instret(b_instret));

   multicycle_control #(.CNT_W(32), .RESET_PC_HOLD(3)) dut_h (
      .clk(clk), .rst_n(rst_n_h), .opcode(opcode), .funct3(funct3),
      .branch_taken(branch_taken), .mem_ack(ack_h), .mem_req(h_mem_req),
      .mem_we(h_mem_we), .mem_addr_sel(h_mem_addr_sel), .ir_we(h_ir_we), .pc_we(h_pc_we),
      .pc_src_sel(h_pc_src_sel), .alu_a_sel(h_alu_a_sel), .alu_b_sel(h_alu_b_sel),
      .rf_we(h_rf_we), .wb_sel(h_wb_sel), .trap(h_trap), .instret(h_instret));

   typedef struct {
      logic [6:0] opc;
      logic       bt;
      int         fw;   // fetch wait cycles before ack
      int         mw;   // MEM wait cycles before ack
   } vec_t;

   typedef struct {
      int cycles; int fetch_cnt; int mem_cnt; int ir_we_cnt; int ir_we_idx;
      int rf_we_cnt; int mem_we_seen; int wb_sel; int pc_src;
      int alu_a; int alu_b; int trapped; int instret;
   } res_t;

   res_t sb_q[$];
   vec_t vecs[14];
   int   checks = 0;
   int   errors = 0;
   int   exp_instret = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference behaviour of one instruction, derived from the phase sequence.
   function automatic res_t model(input vec_t v, input int base);
      res_t e;
      bit legal, ls, wb, jump;
      e = '{default:0};
      case (v.opc)
         LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISCMEM: legal = 1;
         default: legal = 0;
      endcase
      e.fetch_cnt = v.fw + 1;
      e.ir_we_cnt = 1;
      e.ir_we_idx = v.fw;
      e.instret   = base;
      if (!legal) begin
         e.trapped = 1;
         e.cycles  = v.fw + 2;
      end else begin
         ls   = (v.opc == LOAD) || (v.opc == STORE);
         wb   = !((v.opc == BRANCH) || (v.opc == MISCMEM) || (v.opc == STORE));
         jump = (v.opc == JAL) || (v.opc == JALR);
         e.mem_cnt     = ls ? v.mw + 1 : 0;
         e.cycles      = v.fw + 3 + (ls ? v.mw + 1 : 0) + (wb ? 1 : 0);
         e.rf_we_cnt   = wb ? 1 : 0;
         e.mem_we_seen = (v.opc == STORE) ? 1 : 0;
         e.wb_sel      = !wb ? 0 : (v.opc == LOAD) ? 1 : jump ? 2 : 0;
         e.pc_src      = (v.opc == BRANCH) ? int'(v.bt) : jump ? 1 : 0;
         e.alu_a       = ((v.opc == AUIPC) || (v.opc == JAL) || (v.opc == BRANCH)) ? 1 :
                         (v.opc == LUI) ? 2 : 0;
         e.alu_b       = ((v.opc == OP) || (v.opc == BRANCH)) ? 0 : 1;
         e.instret     = base + 1;
      end
      return e;
   endfunction

   // Entered and left at posedge+1 of a FETCH cycle (or inside TRAP).
   task automatic run_instr(input vec_t v);
      res_t o, e;
      int idx = 0, fcnt = 0, mcnt = 0, trap_left = 0;
      int overlap = 0, trap_req = 0, trap_drop = 0;
      bit done = 0;
      o = '{default:0};
      opcode = v.opc;
      branch_taken = v.bt;
      e = model(v, exp_instret);
      sb_q.push_back(e);
      exp_instret = e.instret;
      while (!done && idx < 60) begin
         if (mem_req && !mem_addr_sel) begin
            mem_ack = (fcnt == v.fw); fcnt++;
         end else if (mem_req && mem_addr_sel) begin
            mem_ack = (mcnt == v.mw); mcnt++;
         end else begin
            mem_ack = 1'b1;   // stray ack, must be ignored
         end
         @(negedge clk);
         if (mem_req && !mem_addr_sel) o.fetch_cnt++;
         if (mem_req && mem_addr_sel) begin
            o.mem_cnt++;
            if (mem_we) o.mem_we_seen = 1;
         end
         if (ir_we) begin o.ir_we_cnt++; o.ir_we_idx = idx; end
         if (idx == v.fw + 2) begin o.alu_a = int'(alu_a_sel); o.alu_b = int'(alu_b_sel); end
         if (rf_we) begin
            o.rf_we_cnt++; o.wb_sel = int'(wb_sel);
            if (mem_req) overlap++;
         end
         if (trap_left > 0) begin
            if (mem_req) trap_req++;
            if (!trap) trap_drop++;
            trap_left--;
            if (trap_left == 0) done = 1;
         end else if (trap && !o.trapped) begin
            o.trapped = 1; o.cycles = idx; trap_left = 20;
         end
         if (pc_we) begin o.pc_src = int'(pc_src_sel); o.cycles = idx + 1; done = 1; end
         idx++;
         @(posedge clk); #1;
      end
      o.instret = int'(instret);
      e = sb_q.pop_front();
      check("timeout", 32'(done), 32'd1);
      check("cycles", o.cycles, e.cycles);
      check("fetch_cycles", o.fetch_cnt, e.fetch_cnt);
      check("mem_cycles", o.mem_cnt, e.mem_cnt);
      check("ir_we_count", o.ir_we_cnt, e.ir_we_cnt);
      check("ir_we_cycle", o.ir_we_idx, e.ir_we_idx);
      check("rf_we_count", o.rf_we_cnt, e.rf_we_cnt);
      check("mem_we", o.mem_we_seen, e.mem_we_seen);
      check("wb_sel", o.wb_sel, e.wb_sel);
      check("pc_src_sel", o.pc_src, e.pc_src);
      check("alu_a_sel", o.alu_a, e.alu_a);
      check("alu_b_sel", o.alu_b, e.alu_b);
      check("trap", o.trapped, e.trapped);
      check("instret", o.instret, e.instret);
      check("instret_w4", 32'(b_instret), 32'(e.instret % 16));
      check("rf_we_with_req", overlap, 0);
      check("trap_mem_req", trap_req, 0);
      check("trap_sticky", trap_drop, 0);
      $display("txn opc=%b bt=%0d fw=%0d mw=%0d cycles=%0d trap=%0d instret=%0d",
               v.opc, v.bt, v.fw, v.mw, o.cycles, o.trapped, o.instret);
   endtask

   task automatic reset_pulse();
      mem_ack = 1'b0;
      rst_n = 1'b0;
      #2;
      check("rst_trap", 32'(trap), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_instret", instret, 32'd0);
      exp_instret = 0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int k;
      vecs[0]  = '{OPIMM,   1'b0, 0, 0};
      vecs[1]  = '{OPIMM,   1'b0, 3, 0};
      vecs[2]  = '{BRANCH,  1'b1, 0, 0};
      vecs[3]  = '{BRANCH,  1'b0, 0, 0};
      vecs[4]  = '{LOAD,    1'b0, 0, 2};
      vecs[5]  = '{STORE,   1'b0, 0, 2};
      vecs[6]  = '{LUI,     1'b0, 1, 0};
      vecs[7]  = '{AUIPC,   1'b0, 0, 0};
      vecs[8]  = '{JAL,     1'b0, 0, 0};
      vecs[9]  = '{JALR,    1'b0, 2, 0};
      vecs[10] = '{OP,      1'b1, 0, 0};
      vecs[11] = '{MISCMEM, 1'b0, 0, 0};
      vecs[12] = '{LOAD,    1'b1, 1, 0};
      vecs[13] = '{STORE,   1'b0, 0, 0};

      rst_n = 1'b1; rst_n_h = 1'b1;
      opcode = OPIMM; funct3 = 3'd0; branch_taken = 1'b0; mem_ack = 1'b0; ack_h = 1'b0;
      #2 rst_n = 1'b0; rst_n_h = 1'b0;
      #5;
      check("reset_mem_req", 32'(mem_req), 32'd0);
      check("reset_mem_we", 32'(mem_we), 32'd0);
      check("reset_addr_sel", 32'(mem_addr_sel), 32'd0);
      check("reset_ir_we", 32'(ir_we), 32'd0);
      check("reset_pc_we", 32'(pc_we), 32'd0);
      check("reset_pc_src", 32'(pc_src_sel), 32'd0);
      check("reset_alu_a", 32'(alu_a_sel), 32'd0);
      check("reset_alu_b", 32'(alu_b_sel), 32'd0);
      check("reset_rf_we", 32'(rf_we), 32'd0);
      check("reset_wb_sel", 32'(wb_sel), 32'd0);
      check("reset_trap", 32'(trap), 32'd0);
      check("reset_instret", instret, 32'd0);

      // RESET_PC_HOLD = 3: first mem_req on the 4th edge after release
      @(negedge clk) rst_n_h = 1'b1;
      k = 0;
      while (k < 10 && !h_mem_req) begin
         @(posedge clk); #1; k++;
         check("held_in_reset", 32'(mem_req), 32'd0);
      end
      check("hold_fetch_cycle", k, 4);

      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("first_fetch_req", 32'(mem_req), 32'd1);

      for (int i = 0; i < 14; i++) run_instr(vecs[i]);

      // reset asserted while a load waits in MEM
      opcode = LOAD;
      k = 0;
      while (k < 20 && !(mem_req && mem_addr_sel)) begin
         mem_ack = mem_req && !mem_addr_sel;
         @(posedge clk); #1; k++;
      end
      mem_ack = 1'b0;
      check("reach_mem", 32'(mem_req && mem_addr_sel), 32'd1);
      check("no_early_retire", instret, 32'(exp_instret));
      #2 rst_n = 1'b0;
      #1;
      check("async_drop_req", 32'(mem_req), 32'd0);
      check("async_drop_sel", 32'(mem_addr_sel), 32'd0);
      check("async_instret", instret, 32'd0);
      exp_instret = 0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("refetch_req", 32'(mem_req), 32'd1);
      check("refetch_sel", 32'(mem_addr_sel), 32'd0);

      // SYSTEM and another illegal opcode both halt until reset
      v = '{SYSTEM, 1'b0, 0, 0};
      run_instr(v);
      reset_pulse();
      v = '{OPIMM, 1'b0, 0, 0};
      run_instr(v);
      v = '{7'b1111111, 1'b0, 1, 0};
      run_instr(v);
      reset_pulse();

      // 17 retirements through the 4-bit counter: 15 -> 0 -> 1
      for (int i = 0; i < 17; i++) begin
         v = '{(i % 3 == 0) ? OP : (i % 3 == 1) ? OPIMM : LUI, 1'b0, 0, 0};
         run_instr(v);
      end
      check("wrap_final_w4", 32'(b_instret), 32'd1);
      check("wrap_final_w32", instret, 32'd17);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
